lsu_align: RTL and testbench

Load/store alignment unit directly upstream of the word-organised data memory in the MEM stage.
- Accepts one request per handshake: byte address, store data, funct3, load/store select.
- Generates word address, byte-lane write strobes and lane-replicated write data.
- Extracts and sign/zero-extends load data and returns a completion response.
- Serialises accesses through a small FSM; detects illegal funct3 and (optionally) misalignment.

---
 rtl/lsu_align.sv | 179 +++++++++++++++++
 tb/tb_lsu_align.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit sitting in front of the word-organised
// data memory. Accepts one request at a time, drives word address, byte-lane
// strobes and replicated write data, and formats returned load data.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word accesses are rejected with resp_err
//   undefined - address bits below natural alignment are ignored
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds valid and its payload until that edge. Once
// resp_valid is raised, resp_rdata and resp_err stay stable until the edge
// where resp_ready is sampled high.
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]            state;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            funct3_q;
  logic                  store_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;

  logic                  f3_ok;
  logic                  req_illegal;
  logic [1:0]            lo;
  logic [3:0]            strb_c;
  logic [DATA_W-1:0]     wdata_c;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_W-1:0]     load_fmt;

  // Classify the incoming request: legal funct3 and, optionally, alignment
  always_comb begin
    f3_ok = 1'b0;
    if (req_is_store) begin
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
              (req_funct3 == 3'b010);
    end else begin
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
              (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
              (req_funct3 == 3'b101);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    req_illegal = !f3_ok ||
                  ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_illegal = !f3_ok;
`endif
  end

  // Effective low address bits: sub-alignment bits are dropped per access size
  always_comb begin
    lo = 2'b00;
    case (funct3_q[1:0])
      2'b00:   lo = addr_q[1:0];
      2'b01:   lo = {addr_q[1], 1'b0};
      default: lo = 2'b00;
    endcase
  end

  // Store lane steering: strobe pattern and replicated data per access size
  always_comb begin
    strb_c  = 4'b1111;
    wdata_c = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << lo;
        wdata_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb_c  = lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata_q[15:0]}};
      end
      default: begin
        strb_c  = 4'b1111;
        wdata_c = wdata_q;
      end
    endcase
  end

  // Load lane extraction with sign or zero extension (funct3[2] = unsigned)
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lo)
      2'b00: byte_sel = mem_rdata[7:0];
      2'b01: byte_sel = mem_rdata[15:8];
      2'b10: byte_sel = mem_rdata[23:16];
      2'b11: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_fmt = mem_rdata;
    case (funct3_q[1:0])
      2'b00: load_fmt = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      2'b01: load_fmt = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Control FSM and request/response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            store_q  <= req_is_store;
            err_q    <= req_illegal;
            rdata_q  <= '0;
            state    <= req_illegal ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: state <= store_q ? S_RESP : S_CAPTURE;
        S_CAPTURE: begin
          rdata_q <= load_fmt;
          state   <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode straight from state so reset clears strobes without a clock
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    resp_err   = (state == S_RESP) && err_q;
    resp_rdata = (state == S_RESP) ? rdata_q : '0;
    mem_re     = (state == S_ACCESS) && !store_q;
    mem_we     = (state == S_ACCESS) && store_q;
    mem_addr   = (state == S_ACCESS) ? {addr_q[DM_ADDRESS-1:2], 2'b00} : '0;
    mem_wstrb  = mem_we ? strb_c : 4'b0000;
    mem_wdata  = mem_we ? wdata_c : '0;
    dbg_state  = state;
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: table-driven bench for lsu_align with a word memory model,
// a response scoreboard queue, and hand-written backpressure/reset sequences.
module tb_lsu_align;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_is_store = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [2:0]    req_funct3 = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_state;

  lsu_align #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // word memory model: read data the cycle after mem_re, byte-lane writes
  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
    if (mem_we) begin
      for (int l = 0; l < 4; l++)
        if (mem_wstrb[l]) mem[mem_addr[8:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
    end
  end

  typedef struct {
    logic          st;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [2:0]    f3;
    logic          e_err;
    logic [DW-1:0] e_rd;
    logic          e_we;
    logic          e_re;
    logic [3:0]    e_strb;
    logic [DW-1:0] e_wd;
    logic [AW-1:0] e_ma;
  } vec_t;

  vec_t vecs[$];
  logic [DW:0] exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(logic st, logic [AW-1:0] a, logic [DW-1:0] wd,
                              logic [2:0] f3, logic err, logic [DW-1:0] rd,
                              logic [3:0] strb, logic [DW-1:0] mwd,
                              logic [AW-1:0] ma);
    vec_t v;
    v.st = st; v.addr = a; v.wd = wd; v.f3 = f3; v.e_err = err; v.e_rd = rd;
    v.e_we = st & ~err; v.e_re = ~st & ~err;
    v.e_strb = strb; v.e_wd = mwd; v.e_ma = ma;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // driver: present a request at a falling edge and hold it through acceptance
  task automatic drive_req(input logic st, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [2:0] f3);
    int b;
    b = 0;
    while (!req_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("req_ready_before_issue", req_ready, 1'b1);
    req_is_store = st; req_addr = a; req_wdata = wd; req_funct3 = f3;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // scoreboard: pop expected response, compare, then complete the handshake
  task automatic take_resp(input string name);
    logic [DW:0] e;
    chk({name, "_resp_valid"}, resp_valid, 1'b1);
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_resp"}, {resp_err, resp_rdata}, e);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, "_resp_drop"}, resp_valid, 1'b0);
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int strobes;
    int exp_lat;
    logic lane_bad;
    string nm;
    nm = $sformatf("vec%0d", idx);
    exp_lat = v.e_err ? 1 : (v.st ? 2 : 3);
    exp_q.push_back({v.e_err, v.e_rd});
    drive_req(v.st, v.addr, v.wd, v.f3);
    strobes = 0;
    lane_bad = 1'b0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      if (mem_we || mem_re) strobes++;
      if (!mem_we && (mem_wstrb != 4'b0 || mem_wdata != '0)) lane_bad = 1'b1;
      if (cyc == 1) begin
        chk({nm, "_mem_we"}, mem_we, v.e_we);
        chk({nm, "_mem_re"}, mem_re, v.e_re);
        if (v.e_we) begin
          chk({nm, "_wstrb"}, mem_wstrb, v.e_strb);
          chk({nm, "_wdata"}, mem_wdata, v.e_wd);
        end
        if (v.e_we || v.e_re) chk({nm, "_mem_addr"}, mem_addr, v.e_ma);
      end
      if (resp_valid) break;
      @(negedge clk);
    end
    chk({nm, "_latency"}, cyc, exp_lat);
    chk({nm, "_strobe_cycles"}, strobes, (v.e_we || v.e_re) ? 1 : 0);
    chk({nm, "_idle_lanes_zero"}, lane_bad, 1'b0);
    take_resp(nm);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 128; i++) mem[i] = $urandom_range(0, 1) ? 32'h0 : 32'h0;
    mem[4] = 32'h80FF7F01;

    // {st, addr, wdata, funct3, err, rdata, wstrb, mem_wdata, mem_addr}
    vecs.push_back(mk(1, 9'h006, 32'h000000A5, 3'b000, 0, 32'h0, 4'b0100, 32'hA5A5A5A5, 9'h004));
    vecs.push_back(mk(0, 9'h012, 32'h0, 3'b000, 0, 32'hFFFFFFFF, 4'b0, 32'h0, 9'h010));
    vecs.push_back(mk(0, 9'h013, 32'h0, 3'b100, 0, 32'h00000080, 4'b0, 32'h0, 9'h010));
    vecs.push_back(mk(0, 9'h012, 32'h0, 3'b001, 0, 32'hFFFF80FF, 4'b0, 32'h0, 9'h010));
    vecs.push_back(mk(0, 9'h010, 32'h0, 3'b101, 0, 32'h00007F01, 4'b0, 32'h0, 9'h010));
    vecs.push_back(mk(0, 9'h011, 32'h0, 3'b000, 0, 32'h0000007F, 4'b0, 32'h0, 9'h010));
    vecs.push_back(mk(0, 9'h004, 32'h0, 3'b010, 0, 32'h00A50000, 4'b0, 32'h0, 9'h004));
    vecs.push_back(mk(1, 9'h00A, 32'h1234BEEF, 3'b001, 0, 32'h0, 4'b1100, 32'hBEEFBEEF, 9'h008));
    vecs.push_back(mk(0, 9'h00A, 32'h0, 3'b001, 0, 32'hFFFFBEEF, 4'b0, 32'h0, 9'h008));
    vecs.push_back(mk(0, 9'h010, 32'h0, 3'b011, 1, 32'h0, 4'b0, 32'h0, 9'h0));
    vecs.push_back(mk(0, 9'h010, 32'h0, 3'b110, 1, 32'h0, 4'b0, 32'h0, 9'h0));
    vecs.push_back(mk(0, 9'h010, 32'h0, 3'b111, 1, 32'h0, 4'b0, 32'h0, 9'h0));
    vecs.push_back(mk(1, 9'h020, 32'hFFFFFFFF, 3'b100, 1, 32'h0, 4'b0, 32'h0, 9'h0));
    vecs.push_back(mk(1, 9'h020, 32'hFFFFFFFF, 3'b011, 1, 32'h0, 4'b0, 32'h0, 9'h0));
    vecs.push_back(mk(0, 9'h020, 32'h0, 3'b010, 0, 32'h0, 4'b0, 32'h0, 9'h020));
    vecs.push_back(mk(1, 9'h1FC, 32'hDEADBEEF, 3'b010, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 9'h1FC));
    vecs.push_back(mk(0, 9'h1FC, 32'h0, 3'b010, 0, 32'hDEADBEEF, 4'b0, 32'h0, 9'h1FC));
    vecs.push_back(mk(0, 9'h1FF, 32'h0, 3'b100, 0, 32'h000000DE, 4'b0, 32'h0, 9'h1FC));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 9'h102, 32'hCAFEF00D, 3'b010, 1, 32'h0, 4'b0, 32'h0, 9'h0));
    vecs.push_back(mk(0, 9'h100, 32'h0, 3'b010, 0, 32'h0, 4'b0, 32'h0, 9'h100));
    vecs.push_back(mk(0, 9'h013, 32'h0, 3'b001, 1, 32'h0, 4'b0, 32'h0, 9'h0));
`else
    vecs.push_back(mk(1, 9'h102, 32'hCAFEF00D, 3'b010, 0, 32'h0, 4'b1111, 32'hCAFEF00D, 9'h100));
    vecs.push_back(mk(0, 9'h100, 32'h0, 3'b010, 0, 32'hCAFEF00D, 4'b0, 32'h0, 9'h100));
    vecs.push_back(mk(0, 9'h013, 32'h0, 3'b001, 0, 32'hFFFF80FF, 4'b0, 32'h0, 9'h010));
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_outputs", {resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_wstrb, mem_wdata, mem_addr}, 0);
    chk("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // backpressure: hold response 5 cycles while a second request waits
    exp_q.push_back({1'b0, 32'hFFFFFFFF});
    drive_req(1'b0, 9'h012, 32'h0, 3'b000);
    wait_resp(cyc);
    req_is_store = 1'b1; req_addr = 9'h030; req_wdata = 32'h0000005A; req_funct3 = 3'b000;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid_held", resp_valid, 1'b1);
      chk("bp_rdata_held", resp_rdata, 32'hFFFFFFFF);
      chk("bp_req_ready_low", req_ready, 1'b0);
      chk("bp_no_strobe", {mem_we, mem_re}, 2'b00);
      @(negedge clk);
    end
    take_resp("bp_first");
    chk("bp_not_yet_accepted", dbg_state, 2'd0);
    chk("bp_req_ready_back", req_ready, 1'b1);
    exp_q.push_back({1'b0, 32'h0});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_second_we", mem_we, 1'b1);
    chk("bp_second_wstrb", mem_wstrb, 4'b0001);
    chk("bp_second_wdata", mem_wdata, 32'h5A5A5A5A);
    chk("bp_second_addr", mem_addr, 9'h030);
    wait_resp(cyc);
    chk("bp_second_latency", cyc, 1);
    take_resp("bp_second");

    // reset during the store access cycle
    drive_req(1'b1, 9'h040, 32'h11111111, 3'b010);
    chk("mid_rst_we_before", mem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we_drop", mem_we, 1'b0);
    chk("mid_rst_wstrb_drop", mem_wstrb, 4'b0000);
    chk("mid_rst_state", dbg_state, 2'd0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", dbg_state, 2'd0);
    chk("post_rst_req_ready", req_ready, 1'b1);
    chk("post_rst_resp_valid", resp_valid, 1'b0);
    run_vec(100, mk(0, 9'h040, 32'h0, 3'b010, 0, 32'h0, 4'b0, 32'h0, 9'h040));

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
